// File: rtl/scroll_lanes.sv
// scroll_lanes: shared score-accelerated scroll timebase driving NUM_LANES
// independent horizontal position counters that wrap modulo SCREEN_W.
// Positions, tick and wrap are all registered and change together on the
// cycle after a timer expiry.
module scroll_lanes #(
  parameter int NUM_LANES     = 4,
  parameter int POS_W         = 10,
  parameter int SCREEN_W      = 640,
  parameter int BASE_PERIOD   = 100000,
  parameter int MIN_PERIOD    = 5000,
  parameter int SPEEDUP_SHIFT = 9,
  parameter int CTR_W         = 18
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [6:0]                 score,
  input  logic [NUM_LANES-1:0]       dir,
  input  logic [3*NUM_LANES-1:0]     step,
  output logic [POS_W*NUM_LANES-1:0] pos,
  output logic                       tick,
  output logic [NUM_LANES-1:0]       wrap
);

  // The shifted score is held at full width, so a large score can never alias
  // into a small reload value before it is compared with the cap.
  localparam int SH_W  = 7 + SPEEDUP_SHIFT;
  localparam int CMP_W = (SH_W > CTR_W + 1) ? SH_W : CTR_W + 1;
  localparam int SUM_W = POS_W + 1;

  localparam logic [CMP_W-1:0] RELOAD_CAP = CMP_W'(BASE_PERIOD - MIN_PERIOD);
  localparam logic [CTR_W-1:0] TERM_CNT   = CTR_W'(BASE_PERIOD);
  localparam logic [SUM_W-1:0] SCREEN_S   = SUM_W'(SCREEN_W);

  // One lane's update. Returns {wrapped, new_pos}. The step never exceeds 7
  // and SCREEN_W > 7, so a single add or subtract of SCREEN_W is always a
  // complete modulo reduction and the remainder is preserved.
  function automatic logic [POS_W:0] lane_next(
    input logic [POS_W-1:0] p,
    input logic [2:0]       s,
    input logic             left
  );
    logic [SUM_W-1:0] sum;
    logic [POS_W:0]   res;
    sum = '0;
    res = '0;
    if (!left) begin
      sum = SUM_W'(p) + SUM_W'(s);
      if (sum >= SCREEN_S) begin
        res = {1'b1, POS_W'(sum - SCREEN_S)};
      end else begin
        res = {1'b0, POS_W'(sum)};
      end
    end else begin
      if (SUM_W'(p) < SUM_W'(s)) begin
        sum = SUM_W'(p) + SCREEN_S - SUM_W'(s);
        res = {1'b1, POS_W'(sum)};
      end else begin
        res = {1'b0, p - POS_W'(s)};
      end
    end
    return res;
  endfunction

  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             tick_q, tick_d;
  logic [NUM_LANES-1:0] wrap_q, wrap_d;
  logic [POS_W-1:0] pos_q [NUM_LANES];
  logic [POS_W-1:0] pos_d [NUM_LANES];

  logic [CMP_W-1:0] shifted;
  logic [CMP_W-1:0] reload_full;
  logic [CTR_W-1:0] reload;
  logic             expire;

  // Reload value: score speed-up, clamped so the period never drops below MIN_PERIOD.
  always_comb begin
    shifted     = CMP_W'(score) << SPEEDUP_SHIFT;
    reload_full = (shifted > RELOAD_CAP) ? RELOAD_CAP : shifted;
    reload      = CTR_W'(reload_full);
    expire      = enable && (ctr_q >= TERM_CNT);
  end

  // Next state: timer advance, and on expiry a simultaneous update of every lane.
  always_comb begin
    logic [POS_W:0] nxt;
    nxt    = '0;
    ctr_d  = ctr_q;
    tick_d = 1'b0;
    wrap_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pos_d[i] = pos_q[i];
    end
    if (enable) begin
      if (expire) begin
        ctr_d  = reload;
        tick_d = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
          nxt       = lane_next(pos_q[i], step[3*i +: 3], dir[i]);
          pos_d[i]  = nxt[POS_W-1:0];
          wrap_d[i] = nxt[POS_W];
        end
      end else begin
        ctr_d = ctr_q + CTR_W'(1);
      end
    end
  end

  // State registers; reset staggers the lanes evenly across the screen.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        pos_q[i] <= POS_W'((i * SCREEN_W) / NUM_LANES);
      end
    end else begin
      ctr_q  <= ctr_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        pos_q[i] <= pos_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_pack
    assign pos[POS_W*g +: POS_W] = pos_q[g];
  end

  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scroll_lanes.sv
// Randomised and directed bench for scroll_lanes against a period/elapsed
// reference model using plain modulo arithmetic.
module tb_scroll_lanes;

  localparam int NL = 2;
  localparam int PW = 10;
  localparam int SW = 16;
  localparam int BP = 20;
  localparam int MP = 4;
  localparam int SS = 2;
  localparam int CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              enable;
  logic [6:0]        score;
  logic [NL-1:0]     dir;
  logic [3*NL-1:0]   step;
  logic [PW*NL-1:0]  pos;
  logic              tick;
  logic [NL-1:0]     wrap;

  scroll_lanes #(
    .NUM_LANES(NL), .POS_W(PW), .SCREEN_W(SW), .BASE_PERIOD(BP),
    .MIN_PERIOD(MP), .SPEEDUP_SHIFT(SS), .CTR_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .score(score),
    .dir(dir), .step(step), .pos(pos), .tick(tick), .wrap(wrap)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_pos [NL];
  int m_elapsed;
  int m_period;
  int m_tick;
  int m_wrap;
  logic          prev_tick;
  logic [NL-1:0] prev_wrap;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lane_pos(input int i);
    return int'(pos[PW*i +: PW]);
  endfunction

  task automatic model_edge();
    int rl;
    int s;
    if (reset) begin
      for (int i = 0; i < NL; i++) m_pos[i] = (i * SW) / NL;
      m_elapsed = 0;
      m_period  = BP + 1;
      m_tick    = 0;
      m_wrap    = 0;
    end else begin
      m_tick = 0;
      m_wrap = 0;
      if (enable) begin
        m_elapsed++;
        if (m_elapsed == m_period) begin
          rl = int'(score) * (1 << SS);
          if (rl > BP - MP) rl = BP - MP;
          m_period  = BP - rl + 1;
          m_elapsed = 0;
          m_tick    = 1;
          for (int i = 0; i < NL; i++) begin
            s = int'(step[3*i +: 3]);
            if (!dir[i]) begin
              if (m_pos[i] + s >= SW) m_wrap |= (1 << i);
              m_pos[i] = (m_pos[i] + s) % SW;
            end else begin
              if (m_pos[i] < s) m_wrap |= (1 << i);
              m_pos[i] = (m_pos[i] - s + SW) % SW;
            end
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < NL; i++) chk($sformatf("pos%0d", i), lane_pos(i), m_pos[i]);
    chk("tick", tick, m_tick);
    chk("wrap", wrap, m_wrap);
    chk("tick_run", prev_tick & tick, 0);
    chk("wrap_run", prev_wrap & wrap, 0);
    prev_tick = tick;
    prev_wrap = wrap;
  endtask

  task automatic wait_tick(input string tag, input int exp);
    int n;
    bit seen;
    seen = 1'b0;
    for (n = 1; n <= 200; n++) begin
      cycle();
      if (tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, seen ? n : -1, exp);
  endtask

  // walk both lanes rightward to the requested positions at the capped period
  task automatic steer(input int t0, input int t1);
    int d0;
    int d1;
    for (int k = 0; k < 6; k++) begin
      d0 = (t0 - m_pos[0] + SW) % SW;
      d1 = (t1 - m_pos[1] + SW) % SW;
      if (d0 == 0 && d1 == 0) break;
      dir  = '0;
      step = {3'(d1 > 7 ? 7 : d1), 3'(d0 > 7 ? 7 : d0)};
      wait_tick("steer_period", 5);
    end
  endtask

  initial begin
    int p1;
    reset     = 1'b1;
    enable    = 1'b1;
    score     = '0;
    dir       = '0;
    step      = {3'd2, 3'd2};
    prev_tick = 1'b0;
    prev_wrap = '0;

    repeat (3) cycle();
    chk("rst_pos0", lane_pos(0), 0);
    chk("rst_pos1", lane_pos(1), 8);
    chk("rst_tick", tick, 0);
    reset = 1'b0;

    wait_tick("first_tick_lat", 21);
    chk("first_pos0", lane_pos(0), 2);
    chk("first_pos1", lane_pos(1), 10);
    wait_tick("period_base", 21);

    score = 7'd3;
    wait_tick("period_pre_score", 21);
    wait_tick("period_score3", 9);
    repeat (3) cycle();
    score = 7'd10;
    wait_tick("period_mid_change", 6);
    wait_tick("period_capped", 5);

    repeat (2) cycle();
    enable = 1'b0;
    repeat (50) cycle();
    enable = 1'b1;
    wait_tick("resume_remaining", 3);

    step = {3'd0, 3'd3};
    p1   = lane_pos(1);
    wait_tick("step0_period", 5);
    chk("step0_hold", lane_pos(1), p1);
    chk("step0_nowrap", wrap[1], 0);

    steer(12, 14);
    dir  = 2'b00;
    step = {3'd3, 3'd3};
    wait_tick("wrap_r_period", 5);
    chk("wrap_r_pos0", lane_pos(0), 15);
    chk("wrap_r_pos1", lane_pos(1), 1);
    chk("wrap_r_flags", wrap, 2'b10);

    steer(13, 5);
    dir  = 2'b00;
    step = {3'd0, 3'd3};
    wait_tick("wrap_edge_period", 5);
    chk("wrap_edge_pos0", lane_pos(0), 0);
    chk("wrap_edge_flags", wrap, 2'b01);

    steer(1, 2);
    dir  = 2'b11;
    step = {3'd2, 3'd2};
    wait_tick("wrap_l_period", 5);
    chk("wrap_l_pos0", lane_pos(0), 15);
    chk("wrap_l_pos1", lane_pos(1), 0);
    chk("wrap_l_flags", wrap, 2'b01);

    repeat (4) cycle();
    reset = 1'b1;
    cycle();
    chk("rst_pre_exp_tick", tick, 0);
    chk("rst_pre_exp_pos0", lane_pos(0), 0);
    chk("rst_pre_exp_pos1", lane_pos(1), 8);
    reset = 1'b0;
    dir   = '0;
    step  = {3'd2, 3'd2};
    wait_tick("post_reset_lat", 21);

    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        dir  = NL'($urandom);
        step = (3*NL)'($urandom);
      end
      if ($urandom_range(0, 29) == 0) score = 7'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      reset  = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
